// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Purpose:
//   Sequencer for a shared 4x4 multiply/accumulate datapath. After a start
//   request it accepts len operand pairs, at most one per cycle, and adds up
//   their products. It then presents the total to the consumer and holds it
//   until the consumer takes it. The two-pair case computes A*B + C*D.
//
// Configuration macro:
//   MAC_SAT_EN  undefined (default): the accumulator wraps mod 2**ACC_W.
//               defined: on the first overflow the accumulator clamps to
//               2**ACC_W-1 and stays there for the rest of the run.
//               out_ovf_o is a sticky overflow flag in both builds.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   start_i      begin a run (sampled only in IDLE)
//   len_i        number of operand pairs, sampled together with start_i
//   busy_o       high whenever the controller is not idle
//   in_valid_i   operand pair valid
//   in_ready_o   controller accepts a pair this cycle (RUN state)
//   in_a_i       multiplicand, unsigned 4 bit
//   in_b_i       multiplier, unsigned 4 bit
//   out_valid_o  result valid (DONE state)
//   out_ready_i  consumer takes the result
//   out_sum_o    accumulated sum
//   out_ovf_o    sticky: the sum exceeded 2**ACC_W-1 during the run
// -----------------------------------------------------------------------------

module mac_seq_ctrl #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ACC_W = 9    // must be >= 8 so that one product fits
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_a_i,
    input  logic [3:0]       in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic             out_ovf_o
);

    localparam int unsigned PadW = ACC_W + 1 - 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic [7:0]         prod;
    logic [ACC_W:0]     sum_ext;
    logic               hs;

    // The product is computed at full 8-bit width and the sum one bit wider
    // than the accumulator, so its top bit is the overflow indicator.
    assign prod    = {4'b0000, in_a_i} * {4'b0000, in_b_i};
    assign sum_ext = {1'b0, acc_q} + {{PadW{1'b0}}, prod};
    assign hs      = in_valid_i && (state_q == StRun);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        rem_d   = len_i;
                        state_d = StRun;
                    end else begin
                        // Empty run: report a zero sum straight away.
                        state_d = StDone;
                    end
                end
            end

            StRun: begin
                if (hs) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (sum_ext[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
`ifdef MAC_SAT_EN
                    // Once clamped, keep the maximum until the run ends.
                    if (sum_ext[ACC_W] || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
`else
                    acc_d = sum_ext[ACC_W-1:0];
`endif
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                // start_i is deliberately not looked at here, even in the
                // hand-off cycle; the requester re-asserts it in IDLE.
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs decode registers only; no path from in_* to out_*.
    assign busy_o      = (state_q != StIdle);
    assign in_ready_o  = (state_q == StRun);
    assign out_valid_o = (state_q == StDone);
    assign out_sum_o   = acc_q;
    assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_ctrl
//
// Self-checking bench for mac_seq_ctrl with default parameters. Directed
// vectors come from a table; random runs are checked against a simple
// arithmetic model of sum-of-products with wrap or clamp. Define MAC_SAT_EN
// for both files to exercise the saturating build.
// -----------------------------------------------------------------------------

module tb_mac_seq_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = 9;
    localparam int unsigned MaxV  = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    int checks;
    int errors;

    // Operand pairs for the run in progress.
    int unsigned pa [16];
    int unsigned pb [16];

    mac_seq_ctrl #(
        .CNT_W(CNT_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_ovf_o  (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int unsigned act,
                                input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: running sum of products; overflow is any partial sum
    // above 2**ACC_W-1, after which the value wraps or clamps.
    function automatic void model(input int n, output int unsigned sum, output bit ovf);
        int unsigned acc;
        acc = 0;
        ovf = 0;
        for (int i = 0; i < n; i++) begin
            acc = acc + pa[i] * pb[i];
            if (acc > MaxV) begin
                ovf = 1;
`ifdef MAC_SAT_EN
                acc = MaxV;
`else
                acc = acc % (MaxV + 1);
`endif
            end
`ifdef MAC_SAT_EN
            if (ovf) acc = MaxV;
`endif
        end
        sum = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run from IDLE back to IDLE. gap = idle cycles before each
    // pair (start held high with len=0 then, to prove it is ignored); hold =
    // DONE cycles with out_ready low (start high, including the hand-off).
    task automatic run(input int n, input int gap, input int hold,
                       output int unsigned sum, output bit ovf);
        int unsigned first_sum;
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = '0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = 1'b1;
                tick();
                chk("gap_in_ready", in_ready, 1);
                chk("gap_no_valid", out_valid, 0);
            end
            start    = 1'b0;
            chk("in_ready_before_pair", in_ready, 1);
            in_valid = 1'b1;
            in_a     = 4'(pa[i]);
            in_b     = 4'(pb[i]);
            tick();
            in_valid = 1'b0;
            in_a     = 4'($urandom);
            in_b     = 4'($urandom);
        end
        // One cycle after the last handshake (or after start for len=0).
        chk("out_valid_latency", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        first_sum = out_sum;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_sum_stable", out_sum, first_sum);
        end
        sum       = out_sum;
        ovf       = out_ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        start = 1'b0;
        tick();
        chk("idle_stays", busy, 0);
    endtask

    typedef struct {
        int          n;
        int unsigned a [4];
        int unsigned b [4];
        int          gap;
        int          hold;
        int unsigned exp_sum;
        bit          exp_ovf;
    } vec_t;

    vec_t        vecs [6];
    int unsigned got_sum;
    bit          got_ovf;
    int unsigned ref_sum;
    bit          ref_ovf;

    initial begin
        vecs[0] = '{2, '{1, 15, 0, 0}, '{5, 7, 0, 0}, 0, 0, 110, 0};
        vecs[1] = '{2, '{5, 11, 0, 0}, '{13, 7, 0, 0}, 0, 1, 142, 0};
        vecs[2] = '{2, '{9, 15, 0, 0}, '{5, 5, 0, 0}, 0, 0, 120, 0};
`ifdef MAC_SAT_EN
        vecs[3] = '{3, '{15, 15, 15, 0}, '{15, 15, 15, 0}, 0, 0, 511, 1};
`else
        vecs[3] = '{3, '{15, 15, 15, 0}, '{15, 15, 15, 0}, 0, 0, 163, 1};
`endif
        vecs[4] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 2, 0, 0};
        vecs[5] = '{4, '{2, 4, 6, 8}, '{3, 5, 7, 9}, 3, 5, 140, 0};

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        tick();

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                pa[i] = vecs[v].a[i];
                pb[i] = vecs[v].b[i];
            end
            run(vecs[v].n, vecs[v].gap, vecs[v].hold, got_sum, got_ovf);
            chk($sformatf("vec%0d_sum", v), got_sum, vecs[v].exp_sum);
            chk($sformatf("vec%0d_ovf", v), 32'(got_ovf), 32'(vecs[v].exp_ovf));
        end

        // Reset mid-run after one of three pairs.
        start = 1'b1;
        len   = 4'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 4'd5;
        in_b     = 4'd6;
        tick();
        in_valid = 1'b0;
        chk("midrun_partial", out_sum, 30);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sum", out_sum, 0);
        chk("midrst_out_ovf", out_ovf, 0);
        tick();
        rst = 1'b0;
        tick();
        pa[0] = 3;
        pb[0] = 4;
        run(1, 0, 0, got_sum, got_ovf);
        chk("post_rst_sum", got_sum, 12);
        chk("post_rst_ovf", 32'(got_ovf), 0);

        // Random runs against the model.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                pa[i] = $urandom_range(0, 15);
                pb[i] = $urandom_range(0, 15);
            end
            model(n, ref_sum, ref_ovf);
            run(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), got_sum, got_ovf);
            chk($sformatf("rand%0d_sum", r), got_sum, ref_sum);
            chk($sformatf("rand%0d_ovf", r), 32'(got_ovf), 32'(ref_ovf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
